udp_rx_data_buffer: RTL and testbench

Store-and-forward receive buffer for the UDP path, the receive-side counterpart of the UDP transmit data FIFO. The UDP/IP receive parser writes payload bytes into it, one byte per cycle, with no backpressure. A packet becomes visible to the application only after its last byte arrives error-free. Errored or overflowing packets are discarded by rewinding the write pointer. The read side has a prefetch interface (`rd_en`/`rd_vld`) plus a per-packet length.

---
 rtl/udp_rx_data_buffer_pkg.sv | 13 +
 rtl/udp_rx_sdpram.sv | 27 ++
 rtl/udp_rx_data_buffer.sv | 158 +++++++++++++++
 tb/tb_udp_rx_data_buffer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_rx_data_buffer_pkg.sv
// Shared widths and write-side FSM encoding for the UDP receive buffer.
package udp_rx_pkg;

    localparam int UDP_BYTE_W = 8;
    localparam int UDP_LEN_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        OVF  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/udp_rx_sdpram.sv
// Simple dual-port RAM: one write port, one read port, registered read (1 cycle).
// A read and a write to the same address on one edge returns the old contents.
module udp_rx_sdpram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/udp_rx_data_buffer.sv
// Store-and-forward UDP receive buffer: packets become readable 2 cycles after an error-free last byte.
// No input backpressure (bad or overflowing packets are rewound and counted); FWFT read side, rd_en consumes.
module udp_rx_data_buffer
    import udp_rx_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int LEN_FIFO_AW = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    input  logic [UDP_BYTE_W-1:0] in_data,
    input  logic                  in_last,
    input  logic                  in_err,
    output logic                  rd_pkt_vld,
    output logic [UDP_LEN_W-1:0]  rd_pkt_len,
    input  logic                  rd_en,
    output logic                  rd_vld,
    output logic [UDP_BYTE_W-1:0] rd_data,
    output logic                  rd_last,
    output logic [UDP_LEN_W-1:0]  drop_cnt
);

    localparam logic [ADDR_W:0]      DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]      PTR_INC  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [LEN_FIFO_AW:0] LF_DEPTH = {1'b1, {LEN_FIFO_AW{1'b0}}};
    localparam logic [LEN_FIFO_AW:0] LF_INC   = {{LEN_FIFO_AW{1'b0}}, 1'b1};

    wr_state_t r_state, w_state_nxt;
    logic [ADDR_W:0]       r_wr_ptr, r_cmt_ptr, r_rd_ptr;
    logic [UDP_LEN_W-1:0]  r_len_cnt, r_drop_cnt, r_ocnt;
    logic [LEN_FIFO_AW:0]  r_lf_wr_ptr, r_lf_rd_ptr, r_lf_vis_ptr, w_lf_rd_ptr_nxt;
    logic                  r_inflight;
    logic [1:0]            r_pf_cnt, w_pf_after_pop, w_pf_occ;
    logic [UDP_BYTE_W-1:0] r_pf0, r_pf1, w_ram_q;
    logic [UDP_LEN_W-1:0]  w_lf_q;
    logic w_full, w_lf_full, w_wr_en, w_commit, w_drop;
    logic w_pop_byte, w_pkt_done, w_issue;

    assign w_full    = (r_wr_ptr - r_rd_ptr) == DEPTH;
    assign w_lf_full = (r_lf_wr_ptr - r_lf_rd_ptr) == LF_DEPTH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_commit    = 1'b0;
        w_drop      = 1'b0;
        if (in_vld) begin
            if (r_state == OVF || w_full) begin
                // A byte that finds the RAM full is never written, so the packet is already lost.
                if (in_last) begin
                    w_drop      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = OVF;
                end
            end else if (in_last) begin
                w_state_nxt = IDLE;
                if (in_err || w_lf_full) begin
                    w_drop = 1'b1;
                end else begin
                    w_wr_en  = 1'b1;
                    w_commit = 1'b1;
                end
            end else begin
                w_wr_en     = 1'b1;
                w_state_nxt = RECV;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_cmt_ptr   <= '0;
            r_len_cnt   <= '0;
            r_drop_cnt  <= '0;
            r_lf_wr_ptr <= '0;
        end else begin
            if (w_drop) begin
                r_wr_ptr  <= r_cmt_ptr;
                r_len_cnt <= '0;
                if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 16'd1;
            end else if (w_wr_en) begin
                r_wr_ptr  <= r_wr_ptr + PTR_INC;
                r_len_cnt <= w_commit ? '0 : r_len_cnt + 16'd1;
                if (w_commit) r_cmt_ptr <= r_wr_ptr + PTR_INC;
            end
            if (w_commit) r_lf_wr_ptr <= r_lf_wr_ptr + LF_INC;
        end
    end

    udp_rx_sdpram #(.DATA_W(UDP_BYTE_W), .ADDR_W(ADDR_W)) u_data_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_ram_q)
    );

    // Length RAM is addressed with the post-pop head so its output always tracks the current head.
    udp_rx_sdpram #(.DATA_W(UDP_LEN_W), .ADDR_W(LEN_FIFO_AW)) u_len_ram (
        .clk     (clk),
        .i_we    (w_commit),
        .i_waddr (r_lf_wr_ptr[LEN_FIFO_AW-1:0]),
        .i_wdata (r_len_cnt + 16'd1),
        .i_raddr (w_lf_rd_ptr_nxt[LEN_FIFO_AW-1:0]),
        .o_rdata (w_lf_q)
    );

    assign rd_pkt_vld = r_lf_vis_ptr != r_lf_rd_ptr;
    assign rd_pkt_len = rd_pkt_vld ? w_lf_q : '0;
    assign rd_vld     = r_pf_cnt != 2'd0;
    assign rd_data    = r_pf0;
    assign rd_last    = rd_vld && rd_pkt_vld && ((r_ocnt + 16'd1) == rd_pkt_len);
    assign drop_cnt   = r_drop_cnt;

    assign w_pop_byte      = rd_en && rd_vld;
    assign w_pkt_done      = w_pop_byte && rd_last;
    assign w_lf_rd_ptr_nxt = r_lf_rd_ptr + (w_pkt_done ? LF_INC : '0);
    assign w_pf_after_pop  = r_pf_cnt - {1'b0, w_pop_byte};
    assign w_pf_occ        = w_pf_after_pop + {1'b0, r_inflight};
    assign w_issue         = (r_rd_ptr != r_cmt_ptr) && (w_pf_occ < 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr     <= '0;
            r_inflight   <= 1'b0;
            r_pf_cnt     <= '0;
            r_pf0        <= '0;
            r_pf1        <= '0;
            r_ocnt       <= '0;
            r_lf_rd_ptr  <= '0;
            r_lf_vis_ptr <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) r_rd_ptr <= r_rd_ptr + PTR_INC;
            if (w_pop_byte) r_pf0 <= r_pf1;
            // The byte returning from RAM lands behind whatever survives this cycle's pop.
            if (r_inflight) begin
                if (w_pf_after_pop == 2'd0) r_pf0 <= w_ram_q;
                else                        r_pf1 <= w_ram_q;
            end
            r_pf_cnt <= w_pf_occ;
            if (w_pkt_done)      r_ocnt <= '0;
            else if (w_pop_byte) r_ocnt <= r_ocnt + 16'd1;
            r_lf_rd_ptr  <= w_lf_rd_ptr_nxt;
            r_lf_vis_ptr <= r_lf_wr_ptr;
        end
    end

endmodule

// File: tb/tb_udp_rx_data_buffer.sv
// Bench for udp_rx_data_buffer: random/directed packets against a byte-queue scoreboard.
module tb_udp_rx_data_buffer;

    localparam int AW    = 9;
    localparam int DEPTH = 512;
    localparam int LFD   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_vld = 1'b0, in_last = 1'b0, in_err = 1'b0, rd_en = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        rd_pkt_vld, rd_vld, rd_last;
    logic [15:0] rd_pkt_len, drop_cnt;
    logic [7:0]  rd_data;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    int         len_q[$];
    logic [7:0] pkt[$];
    exp_t       m_e;
    int checks = 0, errors = 0, drop_exp = 0, rd_mode = 0, pkts_read = 0;
    int bub, p0, gap, n;
    bit err;

    always #5 clk = ~clk;

    udp_rx_data_buffer #(.ADDR_W(AW), .LEN_FIFO_AW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (in_vld),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_err     (in_err),
        .rd_pkt_vld (rd_pkt_vld),
        .rd_pkt_len (rd_pkt_len),
        .rd_en      (rd_en),
        .rd_vld     (rd_vld),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .drop_cnt   (drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reader: 0 = idle, 1 = always reading, 2 = random stalls.
    initial forever begin
        @(posedge clk);
        #1;
        rd_en = (rd_mode == 1) || (rd_mode == 2 && $urandom_range(3) != 0);
    end

    // Monitor: every consumed byte is checked against the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n && rd_vld && rd_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got 0x%0h, expected no byte", rd_data);
            end else begin
                m_e = exp_q.pop_front();
                check("rd_data", rd_data, m_e.d);
                check("rd_last", rd_last, m_e.last);
                check("rd_pkt_vld", rd_pkt_vld, 1);
                check("rd_pkt_len", rd_pkt_len, len_q[0]);
                if (m_e.last) begin
                    void'(len_q.pop_front());
                    pkts_read++;
                end
            end
        end
    end

    // Reference decision: a packet commits only if it is good, fits beside the
    // unread bytes and finds a free length slot.
    task automatic send_pkt(input bit bad);
        int  len = pkt.size();
        bit  commit = !bad && (exp_q.size() + len <= DEPTH) && (len_q.size() < LFD);
        if (commit) begin
            for (int i = 0; i < len; i++) exp_q.push_back({pkt[i], i == len - 1});
            len_q.push_back(len);
        end else begin
            drop_exp++;
        end
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            in_vld  = 1'b1;
            in_data = pkt[i];
            in_last = (i == len - 1);
            in_err  = bad && (i == len - 1);
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            in_vld  = 1'b0;
            in_last = 1'b0;
            in_err  = 1'b0;
        end
    endtask

    task automatic make_pkt(input int len);
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || rd_vld) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 4000) begin
            errors++;
            $display("FAIL drain_%s: %0d bytes still pending, expected 0", name, exp_q.size());
        end
        @(negedge clk);
        check({"pkt_vld_after_", name}, rd_pkt_vld, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_pkt_vld"}, rd_pkt_vld, 0);
        check({tag, "_rd_pkt_len"}, rd_pkt_len, 0);
        check({tag, "_rd_vld"}, rd_vld, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_last"}, rd_last, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 check_zero("in_reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_zero("after_reset");

        // Basic 64-byte packet with commit-to-read latency.
        pkt.delete();
        for (int i = 0; i < 64; i++) pkt.push_back(8'(i));
        send_pkt(1'b0);
        idle(1);
        @(negedge clk);
        check("basic_pkt_vld_T", rd_pkt_vld, 0);
        @(negedge clk);
        check("basic_pkt_vld_T1", rd_pkt_vld, 1);
        check("basic_rd_vld_T1", rd_vld, 0);
        check("basic_len_T1", rd_pkt_len, 64);
        @(negedge clk);
        check("basic_rd_vld_T2", rd_vld, 1);
        check("basic_first_byte", rd_data, 0);
        @(posedge clk);
        rd_mode = 1;
        bub = 0;
        repeat (64) begin
            @(negedge clk);
            if (!rd_vld) bub++;
        end
        check("basic_bubbles", bub, 0);
        wait_drain("basic");
        check("basic_drop_cnt", drop_cnt, drop_exp);

        // Errored packet followed by a good one.
        make_pkt(10);
        send_pkt(1'b1);
        pkt.delete();
        pkt.push_back(8'hA1);
        pkt.push_back(8'hA2);
        pkt.push_back(8'hA3);
        send_pkt(1'b0);
        idle(1);
        wait_drain("err");
        check("err_drop_cnt", drop_cnt, drop_exp);

        // Overflow: 400 + 200 bytes with no reads, then a full-depth packet.
        rd_mode = 0;
        idle(2);
        make_pkt(400);
        send_pkt(1'b0);
        make_pkt(200);
        send_pkt(1'b0);
        idle(3);
        check("ovf_drop_cnt", drop_cnt, drop_exp);
        rd_mode = 1;
        wait_drain("ovf_first");
        rd_mode = 0;
        idle(3);
        make_pkt(512);
        send_pkt(1'b0);
        idle(3);
        check("ovf_full_depth_pkt_vld", rd_pkt_vld, 1);
        check("ovf_full_depth_len", rd_pkt_len, 512);
        rd_mode = 1;
        wait_drain("ovf_full_depth");
        check("ovf_drop_cnt_end", drop_cnt, drop_exp);

        // Length FIFO full: 17 one-byte packets, no reads.
        rd_mode = 0;
        idle(3);
        p0 = pkts_read;
        for (int i = 0; i < 17; i++) begin
            make_pkt(1);
            send_pkt(1'b0);
        end
        idle(3);
        check("lf_drop_cnt", drop_cnt, drop_exp);
        rd_mode = 1;
        wait_drain("lf");
        check("lf_pkts_read", pkts_read - p0, 16);

        // Concurrent writes and continuous reads across several wraps.
        for (int k = 0; k < 150; k++) begin
            n   = ($urandom_range(7) == 0) ? 1 : $urandom_range(40, 1);
            err = ($urandom_range(7) == 0);
            make_pkt(n);
            send_pkt(err);
            gap = $urandom_range(2);
            if (gap > 0) idle(gap);
        end
        idle(1);
        wait_drain("wrap");
        check("wrap_drop_cnt", drop_cnt, drop_exp);

        // Random read stalls with a bounded backlog.
        rd_mode = 2;
        for (int k = 0; k < 12; k++) begin
            make_pkt($urandom_range(30, 1));
            send_pkt($urandom_range(7) == 0);
            gap = $urandom_range(3);
            if (gap > 0) idle(gap);
        end
        idle(1);
        wait_drain("stall");
        check("stall_drop_cnt", drop_cnt, drop_exp);

        // Reset mid-packet and mid-read.
        rd_mode = 0;
        idle(2);
        make_pkt(20);
        send_pkt(1'b0);
        idle(1);
        rd_mode = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            in_vld  = 1'b1;
            in_data = 8'(i + 16);
            in_last = 1'b0;
        end
        @(posedge clk);
        #3;
        rst_n  = 1'b0;
        in_vld = 1'b0;
        #1 check_zero("mid_reset");
        exp_q.delete();
        len_q.delete();
        drop_exp = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_rd_vld", rd_vld, 0);
        check("post_reset_pkt_vld", rd_pkt_vld, 0);
        make_pkt(7);
        send_pkt(1'b0);
        idle(1);
        wait_drain("post_reset");
        check("post_reset_drop_cnt", drop_cnt, drop_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
